// File: rtl/exec_cc_mreg_if.sv
// E-stage to M-register bus for exec_cc_mreg: execute-stage inputs, CC/Cnd results
// and the registered M-stage outputs.
interface exec_cc_mreg_if #(
  parameter int W = 64
);
  logic [2:0]   e_stat;
  logic [3:0]   e_icode;
  logic [3:0]   e_ifun;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] e_valE;
  logic [W-1:0] e_valA;
  logic [3:0]   e_dstE;
  logic [3:0]   e_dstM;
  logic         set_cc;
  logic         cc_inhibit;
  logic         m_stall;
  logic         m_bubble;
  logic         e_Cnd;
  logic [2:0]   cc;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  modport master (
    output e_stat, e_icode, e_ifun, alu_a, alu_b, e_valE, e_valA, e_dstE, e_dstM,
    output set_cc, cc_inhibit, m_stall, m_bubble,
    input  e_Cnd, cc, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  e_stat, e_icode, e_ifun, alu_a, alu_b, e_valE, e_valA, e_dstE, e_dstM,
    input  set_cc, cc_inhibit, m_stall, m_bubble,
    output e_Cnd, cc, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/exec_cc_mreg.sv
// Y86-64 execute back end: condition-code register, jXX/cmovXX condition and E->M register.
// Optional retired-instruction counter (perf_instr) enabled by macro EXEC_PERF_CNT_EN.
module exec_cc_mreg #(
  parameter int         W        = 64,
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [3:0] I_NOP    = 4'h1,
  parameter logic [3:0] I_CMOVXX = 4'h2,
  parameter logic [2:0] S_AOK    = 3'd1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef EXEC_PERF_CNT_EN
  output logic [31:0] perf_instr,
`endif
  exec_cc_mreg_if.slave bus
);

  // Overflow only has meaning for add and sub; sub computes alu_b - alu_a.
  function automatic logic calc_of(input logic [3:0] ifun, input logic a_msb,
                                   input logic b_msb, input logic e_msb);
    logic of;
    case (ifun)
      4'd0:    of = (a_msb == b_msb) && (e_msb != a_msb);
      4'd1:    of = (a_msb != b_msb) && (e_msb != b_msb);
      default: of = 1'b0;
    endcase
    return of;
  endfunction

  function automatic logic eval_cnd(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf;
    logic x;
    logic res;
    zf = cc[2];
    x  = cc[1] ^ cc[0];
    case (ifun)
      4'd0:    res = 1'b1;
      4'd1:    res = x | zf;
      4'd2:    res = x;
      4'd3:    res = zf;
      4'd4:    res = !zf;
      4'd5:    res = !x;
      4'd6:    res = !x && !zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [2:0]   r_cc;
  logic [2:0]   r_m_stat;
  logic [3:0]   r_m_icode;
  logic         r_m_cnd;
  logic [W-1:0] r_m_valE;
  logic [W-1:0] r_m_valA;
  logic [3:0]   r_m_dstE;
  logic [3:0]   r_m_dstM;

  logic         w_zf;
  logic         w_sf;
  logic         w_of;
  logic         w_cnd;
  logic [3:0]   w_dstE;

  // New flags from the current ALU result; Cnd uses only the flags already registered.
  always_comb begin
    w_zf  = (bus.e_valE == {W{1'b0}});
    w_sf  = bus.e_valE[W-1];
    w_of  = calc_of(bus.e_ifun, bus.alu_a[W-1], bus.alu_b[W-1], bus.e_valE[W-1]);
    w_cnd = eval_cnd(r_cc, bus.e_ifun);
    if ((bus.e_icode == I_CMOVXX) && !w_cnd) begin
      w_dstE = RNONE;
    end else begin
      w_dstE = bus.e_dstE;
    end
  end

  // Condition-code register; writes ignore M-register stall and bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cc <= 3'b100;
    end else if (bus.set_cc && !bus.cc_inhibit) begin
      r_cc <= {w_zf, w_sf, w_of};
    end else begin
      r_cc <= r_cc;
    end
  end

  // E->M pipeline register: reset, then stall (beats bubble), then bubble, then load.
  always_ff @(posedge clk) begin
    if (!rst_n || (!bus.m_stall && bus.m_bubble)) begin
      r_m_stat  <= S_AOK;
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_valE  <= {W{1'b0}};
      r_m_valA  <= {W{1'b0}};
      r_m_dstE  <= RNONE;
      r_m_dstM  <= RNONE;
    end else if (bus.m_stall) begin
      r_m_stat  <= r_m_stat;
      r_m_icode <= r_m_icode;
      r_m_cnd   <= r_m_cnd;
      r_m_valE  <= r_m_valE;
      r_m_valA  <= r_m_valA;
      r_m_dstE  <= r_m_dstE;
      r_m_dstM  <= r_m_dstM;
    end else begin
      r_m_stat  <= bus.e_stat;
      r_m_icode <= bus.e_icode;
      r_m_cnd   <= w_cnd;
      r_m_valE  <= bus.e_valE;
      r_m_valA  <= bus.e_valA;
      r_m_dstE  <= w_dstE;
      r_m_dstM  <= bus.e_dstM;
    end
  end

  assign bus.e_Cnd   = w_cnd;
  assign bus.cc      = r_cc;
  assign bus.M_stat  = r_m_stat;
  assign bus.M_icode = r_m_icode;
  assign bus.M_Cnd   = r_m_cnd;
  assign bus.M_valE  = r_m_valE;
  assign bus.M_valA  = r_m_valA;
  assign bus.M_dstE  = r_m_dstE;
  assign bus.M_dstM  = r_m_dstM;

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] r_perf;

  // Saturating count of non-NOP instructions actually loaded into M.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf <= 32'd0;
    end else if (!bus.m_stall && !bus.m_bubble && (bus.e_icode != I_NOP) &&
                 (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end else begin
      r_perf <= r_perf;
    end
  end

  assign perf_instr = r_perf;
`endif

endmodule

// File: tb/tb_exec_cc_mreg.sv
// Self-checking bench for exec_cc_mreg: directed vector table, then random stimulus
// against a flag/condition reference model (perf counter checked under EXEC_PERF_CNT_EN).
module tb_exec_cc_mreg;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] valE;
    logic [3:0]  dstE;
    logic        set_cc;
    logic        inh;
    logic        stall;
    logic        bubble;
    logic        x_cnd;
    logic [2:0]  x_cc;
    logic [3:0]  x_icode;
    logic [63:0] x_valE;
    logic [3:0]  x_dstE;
    logic        x_mcnd;
  } vec_t;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mstate_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  vec_t vec [12];

  logic [2:0]  m_cc;
  mstate_t     m_reg;
  logic [31:0] m_perf;

  exec_cc_mreg_if #(.W(64)) bus ();

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] perf_instr;
`endif

  exec_cc_mreg dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef EXEC_PERF_CNT_EN
    .perf_instr(perf_instr),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic mstate_t m_reset();
    mstate_t s;
    s.stat = 3'd1; s.icode = 4'h1; s.cnd = 1'b0; s.valE = 64'd0;
    s.valA = 64'd0; s.dstE = 4'hF; s.dstM = 4'hF;
    return s;
  endfunction

  // Condition as signed-compare semantics: "less" is SF xor OF.
  function automatic logic model_cnd(input logic [2:0] cc, input logic [3:0] ifun);
    logic e;
    logic less;
    e = cc[2];
    less = cc[1] ^ cc[0];
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return less || e;
      4'd2: return less;
      4'd3: return e;
      4'd4: return !e;
      4'd5: return !less;
      4'd6: return !less && !e;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return MAXP;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_cc"}, 64'(bus.cc), 64'(m_cc));
    chk({tag, "_stat"}, 64'(bus.M_stat), 64'(m_reg.stat));
    chk({tag, "_icode"}, 64'(bus.M_icode), 64'(m_reg.icode));
    chk({tag, "_mcnd"}, 64'(bus.M_Cnd), 64'(m_reg.cnd));
    chk({tag, "_valE"}, bus.M_valE, m_reg.valE);
    chk({tag, "_valA"}, bus.M_valA, m_reg.valA);
    chk({tag, "_dstE"}, 64'(bus.M_dstE), 64'(m_reg.dstE));
    chk({tag, "_dstM"}, 64'(bus.M_dstM), 64'(m_reg.dstM));
`ifdef EXEC_PERF_CNT_EN
    chk({tag, "_perf"}, 64'(perf_instr), 64'(m_perf));
`endif
  endtask

  task automatic rand_inputs();
    bus.e_stat     = 3'($urandom_range(0, 7));
    bus.e_icode    = 4'($urandom_range(0, 15));
    bus.e_ifun     = 4'($urandom_range(0, 15));
    bus.alu_a      = {$urandom, $urandom};
    bus.alu_b      = {$urandom, $urandom};
    bus.e_valE     = {$urandom, $urandom};
    bus.e_valA     = {$urandom, $urandom};
    bus.e_dstE     = 4'($urandom_range(0, 15));
    bus.e_dstM     = 4'($urandom_range(0, 15));
    bus.set_cc     = 1'($urandom_range(0, 1));
    bus.cc_inhibit = 1'($urandom_range(0, 1));
    bus.m_stall    = 1'($urandom_range(0, 1));
    bus.m_bubble   = 1'($urandom_range(0, 1));
  endtask

  task automatic simple_cycle(input logic [3:0] icode, input logic stall, input logic bubble);
    bus.e_icode = icode; bus.e_ifun = 4'd0; bus.set_cc = 1'b0;
    bus.m_stall = stall; bus.m_bubble = bubble;
    tick();
  endtask

  initial begin
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] wide;
    logic        exp_cnd;
    logic        zf;
    logic        sf;
    logic        of;
    n_pass = 0;
    n_total = 0;

    // Directed vectors, applied in order from the reset state (cc = ZF only).
    vec[0]  = '{4'h6, 4'h3, 64'd1023, 64'd1024, 64'd2047, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b000, 4'h6, 64'd2047, 4'h3, 1'b1};
    vec[1]  = '{4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b100, 4'h6, 64'd0, 4'h3, 1'b0};
    vec[2]  = '{4'h6, 4'h0, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b011, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1'b1};
    vec[3]  = '{4'h7, 4'h2, 64'd0, 64'd0, 64'h100, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b011, 4'h7, 64'h100, 4'hF, 1'b0};
    vec[4]  = '{4'h7, 4'h1, 64'd0, 64'd0, 64'h100, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b011, 4'h7, 64'h100, 4'hF, 1'b0};
    vec[5]  = '{4'h6, 4'h2, 64'd1, 64'd3, 64'd1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b000, 4'h6, 64'd1, 4'h4, 1'b0};
    vec[6]  = '{4'h2, 4'h3, 64'd0, 64'd0, 64'h33, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 3'b000, 4'h2, 64'h33, 4'hF, 1'b0};
    vec[7]  = '{4'h2, 4'h4, 64'd0, 64'd0, 64'h33, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b000, 4'h2, 64'h33, 4'h3, 1'b1};
    vec[8]  = '{4'h6, 4'h0, 64'd4, 64'd6, 64'd10, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3'b000, 4'h6, 64'd10, 4'h5, 1'b1};
    vec[9]  = '{4'h6, 4'h0, 64'd2, 64'd3, 64'd5, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b1, 3'b000, 4'h6, 64'd10, 4'h5, 1'b1};
    vec[10] = '{4'h6, 4'h0, 64'd2, 64'd3, 64'd5, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 3'b000, 4'h1, 64'd0, 4'hF, 1'b0};
    vec[11] = '{4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 3'b000, 4'h6, 64'd0, 4'h7, 1'b0};

    // Reset held two cycles under random inputs.
    rst_n = 1'b0;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    m_cc = 3'b100;
    m_reg = m_reset();
    m_perf = 32'd0;
    check_all("reset");

    rst_n = 1'b1;
    bus.e_stat = 3'd1; bus.e_valA = 64'd0; bus.e_dstM = 4'hF;
    for (int i = 0; i < 12; i++) begin
      bus.e_icode = vec[i].icode; bus.e_ifun = vec[i].ifun;
      bus.alu_a = vec[i].a; bus.alu_b = vec[i].b; bus.e_valE = vec[i].valE;
      bus.e_dstE = vec[i].dstE; bus.set_cc = vec[i].set_cc; bus.cc_inhibit = vec[i].inh;
      bus.m_stall = vec[i].stall; bus.m_bubble = vec[i].bubble;
      #1;
      chk($sformatf("vec%0d_cnd", i), 64'(bus.e_Cnd), 64'(vec[i].x_cnd));
      tick();
      chk($sformatf("vec%0d_cc", i), 64'(bus.cc), 64'(vec[i].x_cc));
      chk($sformatf("vec%0d_icode", i), 64'(bus.M_icode), 64'(vec[i].x_icode));
      chk($sformatf("vec%0d_valE", i), bus.M_valE, vec[i].x_valE);
      chk($sformatf("vec%0d_dstE", i), 64'(bus.M_dstE), 64'(vec[i].x_dstE));
      chk($sformatf("vec%0d_mcnd", i), 64'(bus.M_Cnd), 64'(vec[i].x_mcnd));
    end

`ifdef EXEC_PERF_CNT_EN
    // Three real loads, a stall, a bubble and a NOP load leave the count at three.
    rst_n = 1'b0;
    simple_cycle(4'h6, 1'b0, 1'b0);
    rst_n = 1'b1;
    simple_cycle(4'h6, 1'b0, 1'b0);
    simple_cycle(4'h7, 1'b0, 1'b0);
    simple_cycle(4'h2, 1'b0, 1'b0);
    simple_cycle(4'h6, 1'b1, 1'b0);
    simple_cycle(4'h6, 1'b0, 1'b1);
    simple_cycle(4'h1, 1'b0, 1'b0);
    chk("perf_seq", 64'(perf_instr), 64'd3);
`endif

    // Random phase: resynchronise the model through a reset first.
    rst_n = 1'b0;
    tick();
    m_cc = 3'b100;
    m_reg = m_reset();
    m_perf = 32'd0;
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      case ($urandom_range(0, 4))
        0: icode = 4'h1;
        1: icode = 4'h2;
        2: icode = 4'h7;
        3: icode = 4'($urandom_range(0, 15));
        default: icode = 4'h6;
      endcase
      ifun = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      if (icode == 4'h6 && $urandom_range(0, 3) != 0) ifun = 4'($urandom_range(0, 3));
      a = pick_op();
      b = pick_op();
      bus.e_icode = icode; bus.e_ifun = ifun; bus.alu_a = a; bus.alu_b = b;
      if (icode == 4'h6 && ifun == 4'd0)      bus.e_valE = a + b;
      else if (icode == 4'h6 && ifun == 4'd1) bus.e_valE = b - a;
      else if (icode == 4'h6 && ifun == 4'd2) bus.e_valE = a & b;
      else if (icode == 4'h6 && ifun == 4'd3) bus.e_valE = a ^ b;
      else bus.e_valE = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      bus.e_stat = 3'($urandom_range(0, 7));
      bus.e_valA = {$urandom, $urandom};
      bus.e_dstE = 4'($urandom_range(0, 15));
      bus.e_dstM = 4'($urandom_range(0, 15));
      bus.set_cc = (icode == 4'h6) && ($urandom_range(0, 3) != 0);
      bus.cc_inhibit = ($urandom_range(0, 4) == 0);
      bus.m_stall = ($urandom_range(0, 5) == 0);
      bus.m_bubble = ($urandom_range(0, 5) == 0);
      #1;
      exp_cnd = model_cnd(m_cc, ifun);
      chk("rand_cnd", 64'(bus.e_Cnd), 64'(exp_cnd));

      // Flags: overflow means the true 65-bit result does not fit in 64 bits.
      zf = (bus.e_valE == 64'd0);
      sf = ($signed(bus.e_valE) < 0);
      of = 1'b0;
      if (ifun == 4'd0) begin
        wide = {a[63], a} + {b[63], b};
        of = wide[64] ^ wide[63];
      end else if (ifun == 4'd1) begin
        wide = {b[63], b} - {a[63], a};
        of = wide[64] ^ wide[63];
      end
      if (!rst_n) begin
        m_cc = 3'b100;
        m_reg = m_reset();
        m_perf = 32'd0;
      end else begin
        if (bus.set_cc && !bus.cc_inhibit) m_cc = {zf, sf, of};
        if (!bus.m_stall) begin
          if (bus.m_bubble) begin
            m_reg = m_reset();
          end else begin
            m_reg.stat = bus.e_stat; m_reg.icode = icode; m_reg.cnd = exp_cnd;
            m_reg.valE = bus.e_valE; m_reg.valA = bus.e_valA; m_reg.dstM = bus.e_dstM;
            m_reg.dstE = (icode == 4'h2 && !exp_cnd) ? 4'hF : bus.e_dstE;
            if (icode != 4'h1 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
          end
        end
      end
      tick();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_cc_mreg.md
Name: exec_cc_mreg

Overview:
Execute-stage back end of the Y86-64 pipeline. It sits directly downstream of the 64-bit ALU, whose OPq datapath includes the XOR unit, and consumes the ALU result valE together with the ALU operands. The block holds the condition-code register (ZF/SF/OF) and evaluates the jXX/cmovXX condition Cnd. It also implements the E->M pipeline register with stall and bubble control.

Parameters:
W, 64, datapath width of valE, valA, aluA, aluB
RNONE, 4'hF, "no register" destination code
I_NOP, 4'h1, icode inserted on bubble/reset
I_CMOVXX, 4'h2, icode of rrmovq/cmovXX
S_AOK, 3'd1, status code inserted on bubble/reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
e_stat  in  3  instruction status from E register
e_icode  in  4  instruction code
e_ifun  in  4  function code (ALU op for OPq: 0 add, 1 sub, 2 and, 3 xor; condition for jXX/cmovXX)
alu_a  in  W  ALU operand A
alu_b  in  W  ALU operand B
e_valE  in  W  ALU result (sub computes alu_b - alu_a)
e_valA  in  W  valA pass-through
e_dstE  in  4  destination E
e_dstM  in  4  destination M
set_cc  in  1  instruction is OPq; update CC
cc_inhibit  in  1  exception downstream; suppress CC write
m_stall  in  1  hold M register
m_bubble  in  1  load bubble into M register
e_Cnd  out  1  combinational condition result
cc  out  3  {ZF,SF,OF} current CC register
M_stat  out  3  registered status
M_icode  out  4  registered icode
M_Cnd  out  1  registered Cnd
M_valE  out  W  registered valE
M_valA  out  W  registered valA
M_dstE  out  4  registered dstE, squashed when cmov is not taken
M_dstM  out  4  registered dstM

Behaviour:
- Reset: if rst_n is low at a rising edge:
  - cc <= 3'b100 (ZF=1, SF=0, OF=0).
  - M_stat <= S_AOK, M_icode <= I_NOP, M_Cnd <= 0, M_valE <= 0, M_valA <= 0, M_dstE <= RNONE, M_dstM <= RNONE.
  - Reset overrides stall, bubble and CC write.
- New flags, combinational from the current inputs:
  - ZF = (e_valE == 0); SF = e_valE[W-1].
  - OF, ifun 0 (add): (alu_a[W-1] == alu_b[W-1]) && (e_valE[W-1] != alu_a[W-1]).
  - OF, ifun 1 (sub): (alu_a[W-1] != alu_b[W-1]) && (e_valE[W-1] != alu_b[W-1]).
  - OF, ifun 2, 3, or any other value: 0.
- CC write:
  - cc <= {ZF,SF,OF} at the edge when set_cc && !cc_inhibit && rst_n.
  - The write is independent of m_stall and m_bubble.
  - Otherwise cc holds its value.
- e_Cnd is evaluated from the registered cc (flags of earlier instructions), never from the new flags. With X = SF^OF:
  - ifun 0: 1
  - ifun 1: X|ZF
  - ifun 2: X
  - ifun 3: ZF
  - ifun 4: !ZF
  - ifun 5: !X
  - ifun 6: !X&&!ZF
  - ifun >6: 0
- dstE squash: the effective dstE is RNONE when e_icode == I_CMOVXX && !e_Cnd; otherwise it is e_dstE.
- M register update, in priority order at each rising edge:
  1. Reset.
  2. m_stall: all M_* outputs hold. Stall wins over a simultaneous m_bubble.
  3. m_bubble: M_* take their reset values.
  4. Otherwise load e_stat, e_icode, e_Cnd, e_valE, e_valA, effective dstE, e_dstM.
- Latency: inputs appear on M_* one cycle after capture. e_Cnd has zero latency.
- The block performs no arithmetic on e_valE; it only passes it through and tests it.

Optional Feature:
- Macro EXEC_PERF_CNT_EN.
- When defined:
  - Adds output perf_instr [31:0], reset to 0.
  - Increments by 1 at each edge where the M register loads (no reset, no stall, no bubble) and e_icode != I_NOP.
  - Saturates at 32'hFFFFFFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> cc=3'b100, M_icode=1, M_stat=1, M_dstE=M_dstM=4'hF, M_valE=0.
- XOR flags: ifun=3, alu_a=1023, alu_b=1024, e_valE=2047, set_cc=1 -> next cycle cc=3'b000. Then e_valE=0 with set_cc=1 -> cc=3'b100.
- Add overflow: ifun=0, alu_a=alu_b=64'h7FFF_FFFF_FFFF_FFFF, e_valE=64'hFFFF_FFFF_FFFF_FFFE -> cc=3'b011. In the next cycle, ifun=2 (jl) -> e_Cnd=0 and ifun=1 (jle) -> e_Cnd=0.
- cmov squash: cc=3'b000, e_icode=2, ifun=3 (cmove), e_dstE=4'h3 -> M_dstE=4'hF, M_Cnd=0. The same with ifun=4 -> M_dstE=4'h3, M_Cnd=1.
- Stall/bubble:
  - Load M_valE=10 (icode 6), then assert m_stall and m_bubble together with new e_valE=5 -> M_valE stays 10.
  - Release the stall -> bubble: M_icode=1, M_valE=0.
  - set_cc=1 with cc_inhibit=1 -> cc unchanged.
- With EXEC_PERF_CNT_EN: 3 non-NOP loads, 1 stall, 1 bubble, 1 NOP load -> perf_instr=3.
